counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_seq_pkg.sv | 18 +
 rtl/counter_sequencer_edge_detect.sv | 35 +++
 rtl/counter_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared state encoding and default sizing for counter_sequencer
//
// Purpose: one place for the FSM state encoding and the default WIDTH/LIMIT
//          constants, so the top and any tooling agree on the State output code.
// Ports:   none (package).
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_LIMIT = 9;

endpackage

// File: rtl/counter_sequencer_edge_detect.sv
// rtl/counter_sequencer_edge_detect.sv - zero-latency rising-edge detector for a level button
//
// Purpose: flags a rising edge in the same cycle the button is first seen high,
//          so the owning logic can act on that very clock edge.
// Ports:
//   i_clk   - clock, rising edge
//   i_clr   - asynchronous active-high clear of the edge history
//   i_level - button level
//   o_rise  - high while i_level=1 and the level at the previous edge was 0
module edge_detect (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // r_armed stays low for the first edge after a clear. There is no
    // previous sample at that edge, so no rising edge can be claimed; this
    // is also what keeps a button held through clear release from firing.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - start/stop/step up-down counter with terminal-count handling
//
// Purpose: button-driven counter. StartStop toggles between running and paused
//          (or leaves IDLE/DONE), Tick advances while running, Step advances
//          once while paused, and Dir chooses up or down.
// Build option: COUNTER_SEQ_WRAP_EN - when defined, terminal crossings wrap
//          (LIMIT->0 going up, 0->LIMIT going down) and DONE is never entered;
//          when undefined, a crossing holds Count and enters DONE.
// Ports:
//   Clock     - clock, all state updates on the rising edge
//   Clear     - asynchronous active-high reset
//   StartStop - level button, rising edge acts
//   Step      - level button, rising edge requests one advance in PAUSE
//   Dir       - 0 = count up, 1 = count down
//   Tick      - advance enable while in RUN
//   Count     - current count [WIDTH-1:0]
//   Running   - high when the state is RUN
//   Carry     - one-cycle pulse per terminal crossing
//   State     - encoded FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LIMIT = DEFAULT_LIMIT
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             StartStop,
    input  logic             Step,
    input  logic             Dir,
    input  logic             Tick,
    output logic [WIDTH-1:0] Count,
    output logic             Running,
    output logic             Carry,
    output logic [1:0]       State
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_carry;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_carry_nxt;
    logic             w_advance;
    logic             w_at_term;
    logic             w_ss_rise;
    logic             w_step_rise;

    edge_detect u_ss_edge (
        .i_clk   (Clock),
        .i_clr   (Clear),
        .i_level (StartStop),
        .o_rise  (w_ss_rise)
    );

    edge_detect u_step_edge (
        .i_clk   (Clock),
        .i_clr   (Clear),
        .i_level (Step),
        .o_rise  (w_step_rise)
    );

    // The next advance would leave the 0..LIMIT range in the chosen direction.
    assign w_at_term = Dir ? (r_count == '0) : (r_count == LIMIT_W);

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state <= IDLE;
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_carry_nxt = 1'b0;
        w_advance   = 1'b0;

        // A StartStop edge always takes priority. A Step edge in the same
        // cycle is dropped rather than queued.
        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (w_ss_rise) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_ss_rise) begin
                    w_state_nxt = PAUSE;
                end else begin
                    w_advance = Tick;
                end
            end
            PAUSE: begin
                if (w_ss_rise) begin
                    w_state_nxt = RUN;
                end else begin
                    w_advance = w_step_rise;
                end
            end
            DONE: begin
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase

        if (w_advance) begin
            if (w_at_term) begin
                w_carry_nxt = 1'b1;
`ifdef COUNTER_SEQ_WRAP_EN
                w_count_nxt = Dir ? LIMIT_W : '0;
`else
                w_state_nxt = DONE;
`endif
            end else if (Dir) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end
    end

    assign Count   = r_count;
    assign Running = (r_state == RUN);
    assign Carry   = r_carry;
    assign State   = r_state;

endmodule
